period_meter: RTL
=================

// Module: period_meter
// PURPOSE
//  Measures a slow, divided-clock-style input (e.g. a clock divider's output or an external
//  reference) in clk cycles. Reports period, high time and the equivalent divider setting
//  (halfPeriod - 1). Sits beside the clock dividers as a self-check / frequency readout.
// PARAMETERS
//  CNT_W      16      width of period/high/divisor counters and outputs
//  MAX_PERIOD 65535   timeout: cnt reaching this value with no rising edge = signal lost (<= 2^CNT_W-1)
//  LOCK_TOL   1       max |period[n] - period[n-1]| for locked to assert/hold
// PORTS
//  clk          in   1      system clock
//  rst_n        in   1      asynchronous reset, active-low
//  sigIn        in   1      measured signal, asynchronous to clk
//  period       out  CNT_W  clk cycles between the last two detected rising edges
//  highTime     out  CNT_W  clk cycles from that rising edge to the following falling edge
//  divisorEst   out  CNT_W  (period >> 1) - 1, saturating at 0
//  measValid    out  1      1-cycle pulse when period/highTime/divisorEst update
//  locked       out  1      two consecutive periods within LOCK_TOL
//  timeout      out  1      sticky; set on timeout, cleared by the next rising edge
// BEHAVIOUR
//  Reset (rst_n=0, async): all outputs 0, cnt=0, sync flops 0, FSM=IDLE.
//  Sync: sigIn -> s1 -> s2 (2 flops); s3 <= s2. rise = s2&~s3, fall = ~s2&s3.
//   Detection latency: rise/fall asserted 2-3 clk after sigIn transition.
//  FSM IDLE: cnt held 0. On rise: cnt<=1, timeout<=0, go ARMED. No measValid.
//  FSM ARMED (first edge seen, no full period yet): cnt<=cnt+1; fall: hiCapture<=cnt;
//   rise: cnt<=1, go MEASURE, then same capture as below for this edge.
//  FSM MEASURE: cnt<=cnt+1 each cycle. fall: hiCapture<=cnt.
//   rise: period<=cnt, highTime<=hiCapture, divisorEst<=(cnt>>1)-1 (0 if cnt<2),
//   measValid<=1 next cycle (same edge as output update), cnt<=1, prevPeriod<=cnt.
//   locked<=1 if |cnt-prevPeriod| <= LOCK_TOL and prevPeriod valid, else locked<=0.
//  Timeout (ARMED/MEASURE): cnt==MAX_PERIOD and no rise -> timeout<=1, locked<=0,
//   prevPeriod invalid, FSM<=IDLE; period/highTime/divisorEst hold last values.
//  Simultaneous rise and cnt==MAX_PERIOD: rise wins; period<=MAX_PERIOD, no timeout.
//  cnt never wraps: counts up to MAX_PERIOD only.
//  Min supported period: 4 clk; shorter inputs give undefined values but must not hang FSM.
//  highTime 0 if no fall seen within the period (input stuck high between rises).
//  Unsigned arithmetic throughout; difference computed in CNT_W+1 bits.
//  rst_n mid-measurement: immediate return to reset state; first valid after 2 rises.
// STRUCTURE
//  Package period_meter_pkg: CNT_W default, FSM state enum (IDLE, ARMED, MEASURE),
//   DIV_EST function ((p>>1)-1 saturating).
//  Sub-module sync_edge_detect: 2-flop synchronizer + edge register, outputs level, rise, fall.
//  Top: FSM, counter, capture registers, lock compare.
// TESTING
//  Drive sigIn from divider model frequencySel=4 (toggle every 5 clk) -> after 2nd rise
//   period=10, highTime=5, divisorEst=4, measValid 1 cycle/period, locked=1 on 3rd rise.
//  Duty change: high 3 clk / low 7 clk -> period=10, highTime=3, divisorEst=4.
//  Jitter: periods 10,11,13 with LOCK_TOL=1 -> locked 1 after 11, 0 after 13.
//  Stop toggling, MAX_PERIOD=100 -> timeout=1, locked=0 exactly when cnt hits 100;
//   outputs hold; next rise clears timeout, no measValid until following rise.
//  Assert rst_n=0 mid-period -> all outputs 0 asynchronously; resume -> first measValid on
//   2nd rise after release.
//  Rise coincident with cnt==MAX_PERIOD -> period=MAX_PERIOD, measValid=1, timeout stays 0.

Source files
------------

// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter.
//   PM_CNT_W    : default counter/output width
//   pm_state_e  : measurement FSM states
//   div_est()   : equivalent divider setting from a period, (p >> 1) - 1 saturating at 0
package period_meter_pkg;

  localparam int unsigned PM_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } pm_state_e;

  // Evaluated at 32 bits so any counter width up to 32 can use it.
  function automatic logic [31:0] div_est(input logic [31:0] p);
    if (p < 32'd2) return 32'd0;
    return (p >> 1) - 32'd1;
  endfunction

endpackage

// File: rtl/period_meter_sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input plus one edge-history flop.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous reset, active-low
//   sig_i  : asynchronous input
//   rise_o : one-cycle pulse after a synchronized 0->1 transition
//   fall_o : one-cycle pulse after a synchronized 1->0 transition
module period_meter_sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~s3_q;
  assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/period_meter.sv
// Measures a slow input in clk cycles: rise-to-rise period, rise-to-fall high
// time and the equivalent divider setting (period/2 - 1).
// Ports:
//   clk        : system clock
//   rst_n      : asynchronous reset, active-low
//   sigIn      : measured signal, asynchronous to clk
//   period     : cycles between the last two detected rising edges
//   highTime   : cycles from that rising edge to its falling edge (0 if none)
//   divisorEst : (period >> 1) - 1, saturating at 0
//   measValid  : one-cycle pulse when the three results update
//   locked     : two consecutive periods within LOCK_TOL
//   timeout    : sticky, set when no rise arrives within MAX_PERIOD cycles
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned CNT_W      = PM_CNT_W,
  parameter int unsigned MAX_PERIOD = 65535,
  parameter int unsigned LOCK_TOL   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sigIn,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] highTime,
  output logic [CNT_W-1:0] divisorEst,
  output logic             measValid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W:0]   TOL     = (CNT_W+1)'(LOCK_TOL);

  logic rise, fall;

  period_meter_sync_edge_detect u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (sigIn),
    .rise_o (rise),
    .fall_o (fall)
  );

  pm_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] prev_q, prev_d;
  logic             prev_vld_q, prev_vld_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             meas_q, meas_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;

  // Unsigned distance between this period and the previous one, one bit wider
  // so the subtraction cannot wrap.
  logic [CNT_W:0] cnt_x, prev_x, diff;
  assign cnt_x  = {1'b0, cnt_q};
  assign prev_x = {1'b0, prev_q};
  assign diff   = (cnt_x >= prev_x) ? (cnt_x - prev_x) : (prev_x - cnt_x);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a rise on the MAX_PERIOD cycle still counts as a period.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:           if (rise) state_d = ARMED;
      ARMED, MEASURE: begin
        if (rise)                  state_d = MEASURE;
        else if (cnt_q == MAX_CNT) state_d = IDLE;
      end
      default:        state_d = IDLE;
    endcase
  end

  // Counter, captures and status outputs
  always_comb begin
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    period_d   = period_q;
    high_d     = high_q;
    div_d      = div_q;
    meas_d     = 1'b0;
    locked_d   = locked_q;
    timeout_d  = timeout_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise) begin
          cnt_d     = CNT_W'(1);
          hi_d      = '0;
          timeout_d = 1'b0;
        end
      end
      ARMED, MEASURE: begin
        if (cnt_q != MAX_CNT) cnt_d = cnt_q + 1'b1;
        if (fall) hi_d = cnt_q;
        if (rise) begin
          period_d   = cnt_q;
          high_d     = hi_q;
          div_d      = CNT_W'(div_est(32'(cnt_q)));
          meas_d     = 1'b1;
          locked_d   = prev_vld_q && (diff <= TOL);
          prev_d     = cnt_q;
          prev_vld_d = 1'b1;
          cnt_d      = CNT_W'(1);
          // Cleared so a period with no falling edge reports highTime 0.
          hi_d       = '0;
        end else if (cnt_q == MAX_CNT) begin
          cnt_d      = '0;
          timeout_d  = 1'b1;
          locked_d   = 1'b0;
          prev_vld_d = 1'b0;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      hi_q       <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      period_q   <= '0;
      high_q     <= '0;
      div_q      <= '0;
      meas_q     <= 1'b0;
      locked_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      period_q   <= period_d;
      high_q     <= high_d;
      div_q      <= div_d;
      meas_q     <= meas_d;
      locked_q   <= locked_d;
      timeout_q  <= timeout_d;
    end
  end

  assign period     = period_q;
  assign highTime   = high_q;
  assign divisorEst = div_q;
  assign measValid  = meas_q;
  assign locked     = locked_q;
  assign timeout    = timeout_q;

endmodule
